// File: rtl/tile_pixel_renderer.sv
// Tile-map pixel renderer: (x, y) -> tile-map lookup -> glyph row -> coloured framebuffer write.
// Fixed 3-stage pipeline. Optional build macro PELLET_BLINK_EN makes tile id 3 blink every 16 frames.
module tile_pixel_renderer #(
    parameter int                 COLOR_W   = 8,
    parameter logic [COLOR_W-1:0] BG_COLOR  = '0,
    parameter int                 TILE_ID_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [9:0]             x,
    input  logic [8:0]             y,
    input  logic                   in_valid,
    output logic [12:0]            tile_addr,
    input  logic [TILE_ID_W-1:0]   tile_data,
    output logic [TILE_ID_W+2:0]   glyph_addr,
    input  logic [7:0]             glyph_data,
    output logic                   fb_we,
    output logic [9:0]             fb_x,
    output logic [8:0]             fb_y,
    output logic [COLOR_W-1:0]     fb_color,
    output logic                   frame_done,
    output logic [7:0]             frame_count
);

    localparam logic [9:0] X_END  = 10'd640;
    localparam logic [8:0] Y_END  = 9'd480;
    localparam logic [9:0] X_LAST = 10'd639;
    localparam logic [8:0] Y_LAST = 9'd479;

    localparam logic [COLOR_W-1:0] FG_WALL  = COLOR_W'(8'h03);
    localparam logic [COLOR_W-1:0] FG_DOT   = COLOR_W'(8'hFF);
    localparam logic [COLOR_W-1:0] FG_ACTOR = COLOR_W'(8'hFC);

    logic                  v1, v2, v3;
    logic [9:0]            x_s1, x_s2, x_s3;
    logic [8:0]            y_s1, y_s2, y_s3;
    logic [TILE_ID_W-1:0]  tile_id_s3;
    logic [COLOR_W-1:0]    fg;
    logic                  pix_on;
    logic                  last_pix;
    logic [12:0]           row_base;

    // Tile row base = row * 80, built as row*64 + row*16 to avoid a multiplier.
    assign row_base = 13'({y[8:3], 6'b0}) + 13'({y[8:3], 4'b0});

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v1        <= 1'b0;
            x_s1      <= '0;
            y_s1      <= '0;
            tile_addr <= '0;
        end else begin
            v1        <= in_valid && (x < X_END) && (y < Y_END);
            x_s1      <= x;
            y_s1      <= y;
            tile_addr <= row_base + 13'(x[9:3]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v2   <= 1'b0;
            x_s2 <= '0;
            y_s2 <= '0;
        end else begin
            v2   <= v1;
            x_s2 <= x_s1;
            y_s2 <= y_s1;
        end
    end

    assign glyph_addr = {tile_data, y_s2[2:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v3         <= 1'b0;
            x_s3       <= '0;
            y_s3       <= '0;
            tile_id_s3 <= '0;
        end else begin
            v3         <= v2;
            x_s3       <= x_s2;
            y_s3       <= y_s2;
            tile_id_s3 <= tile_data;
        end
    end

    always_comb begin
        fg = FG_ACTOR;
        case (int'(tile_id_s3))
            0:       fg = BG_COLOR;
            1:       fg = FG_WALL;
            2:       fg = FG_DOT;
            3:       fg = FG_DOT;
            default: fg = FG_ACTOR;
        endcase
`ifdef PELLET_BLINK_EN
        // Pellets go dark for the upper half of each 32-frame cycle.
        if (int'(tile_id_s3) == 3 && frame_count[4])
            fg = BG_COLOR;
`endif
    end

    // Glyph bit 7 is the leftmost pixel of the tile row.
    assign pix_on   = glyph_data[3'd7 - x_s3[2:0]];
    assign last_pix = v3 && (x_s3 == X_LAST) && (y_s3 == Y_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fb_we       <= 1'b0;
            fb_x        <= '0;
            fb_y        <= '0;
            fb_color    <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            fb_we      <= v3;
            frame_done <= last_pix;
            if (v3) begin
                fb_x     <= x_s3;
                fb_y     <= y_s3;
                fb_color <= pix_on ? fg : BG_COLOR;
            end
            if (last_pix)
                frame_count <= frame_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_tile_pixel_renderer.sv
// Self-checking bench for tile_pixel_renderer: directed scenarios plus random pixels against a
// per-pixel reference model; behavioural tile-map RAM and glyph ROM with 1-cycle read latency.
`timescale 1ns/1ps
module tb_tile_pixel_renderer;

    localparam logic [7:0] BG = 8'h00;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        in_valid;
    logic [12:0] tile_addr;
    logic [3:0]  tile_data;
    logic [6:0]  glyph_addr;
    logic [7:0]  glyph_data;
    logic        fb_we;
    logic [9:0]  fb_x;
    logic [8:0]  fb_y;
    logic [7:0]  fb_color;
    logic        frame_done;
    logic [7:0]  frame_count;

    tile_pixel_renderer #(.COLOR_W(8), .BG_COLOR(BG), .TILE_ID_W(4)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .in_valid(in_valid),
        .tile_addr(tile_addr), .tile_data(tile_data),
        .glyph_addr(glyph_addr), .glyph_data(glyph_data),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
        .frame_done(frame_done), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    logic [3:0] tile_map  [0:8191];
    logic [7:0] glyph_rom [0:127];

    always @(posedge clk) begin
        tile_data  <= tile_map[tile_addr];
        glyph_data <= glyph_rom[glyph_addr];
    end

    typedef struct { bit v; int px; int py; } pix_t;
    pix_t q[$];
    int   m_x, m_y, m_col, m_cnt;
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tile_of(int px, int py);
        return tile_map[((py % 512) / 8) * 80 + (px % 1024) / 8];
    endfunction

    function automatic logic [7:0] model_color(int px, int py, int cnt);
        int         id;
        logic [7:0] g;
        logic [7:0] fgc;
        id = tile_of(px, py);
        g  = glyph_rom[id * 8 + py % 8];
        case (id)
            0:       fgc = BG;
            1:       fgc = 8'h03;
            2, 3:    fgc = 8'hFF;
            default: fgc = 8'hFC;
        endcase
`ifdef PELLET_BLINK_EN
        if (id == 3 && ((cnt / 16) % 2) == 1) fgc = BG;
`endif
        return g[7 - px % 8] ? fgc : BG;
    endfunction

    task automatic model_clear();
        q.delete();
        m_x = 0; m_y = 0; m_col = 0; m_cnt = 0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_we"},   fb_we, 0);
        chk({tag, "_fbx"},  fb_x, 0);
        chk({tag, "_fby"},  fb_y, 0);
        chk({tag, "_col"},  fb_color, 0);
        chk({tag, "_done"}, frame_done, 0);
        chk({tag, "_cnt"},  frame_count, 0);
        chk({tag, "_taddr"}, tile_addr, 0);
    endtask

    // Drive one pixel (already at a negedge), clock it in, then check everything due this cycle.
    task automatic drive_and_check(input bit v, input int px, input int py);
        pix_t p, g;
        bit   ew, efd;
        in_valid = v;
        x = 10'(px);
        y = 9'(py);
        p.v = v; p.px = px; p.py = py;
        q.push_back(p);
        @(posedge clk);
        #1;
        chk("tile_addr", tile_addr, ((py % 512) / 8) * 80 + (px % 1024) / 8);
        if (q.size() >= 2) begin
            g = q[q.size() - 2];
            chk("glyph_addr", glyph_addr, tile_of(g.px, g.py) * 8 + g.py % 8);
        end
        ew = 0; efd = 0;
        if (q.size() == 4) begin
            p  = q.pop_front();
            ew = p.v && p.px < 640 && p.py < 480;
            if (ew) begin
                m_x   = p.px;
                m_y   = p.py;
                m_col = model_color(p.px, p.py, m_cnt);
                efd   = (p.px == 639 && p.py == 479);
            end
        end
        chk("fb_we", fb_we, ew);
        chk("fb_x", fb_x, m_x);
        chk("fb_y", fb_y, m_y);
        chk("fb_color", fb_color, m_col);
        chk("frame_done", frame_done, efd);
        if (efd) m_cnt = (m_cnt + 1) % 256;
        chk("frame_count", frame_count, m_cnt);
    endtask

    task automatic step(input bit v, input int px, input int py);
        @(negedge clk);
        drive_and_check(v, px, py);
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b1;
        drive_and_check(0, 0, 0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        x        = '0;
        y        = '0;
        for (int i = 0; i < 8192; i++) tile_map[i] = 4'($urandom);
        for (int i = 0; i < 128; i++)  glyph_rom[i] = 8'($urandom);
        tile_map[82]   = 4'd1;  glyph_rom[9]  = 8'h40;
        tile_map[2]    = 4'd2;  glyph_rom[16] = 8'hA5;
        tile_map[4799] = 4'd3;  glyph_rom[31] = 8'hFF;
        model_clear();

        // Held in reset with toggling input: everything stays cleared.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid = ~in_valid;
            x = 10'(17 + i);
            y = 9'(9 + i);
            @(posedge clk);
            #1;
            check_zero("in_reset");
        end

        release_reset();
        step(1, 17, 9);
        chk("first_taddr", tile_addr, 82);
        step(0, 0, 0);
        chk("first_gaddr", glyph_addr, 7'h09);
        step(0, 0, 0);
        step(0, 0, 0);
        chk("first_color", fb_color, 8'h03);

        // Bit select across one glyph row.
        for (int i = 16; i < 24; i++) step(1, i, 0);

        // Bubbles and out-of-range drops.
        step(1, 100, 50);
        step(0, 101, 50);
        step(1, 102, 50);
        step(1, 640, 50);
        step(1, 5, 480);

        // Frame wrap, pellet blink around count 15/16, and count rollover.
        step(1, 638, 479);
        step(1, 639, 479);
        step(1, 0, 0);
        repeat (20)  step(1, 639, 479);
        repeat (240) step(1, 639, 479);
        repeat (4)   step(0, 0, 0);

        // Reset between edges with three pixels in flight.
        step(1, 10, 10);
        step(1, 11, 10);
        step(1, 12, 10);
        #2;
        reset = 1'b0;
        #1;
        check_zero("mid_reset");
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            x = 10'(20 + i);
            @(posedge clk);
            #1;
            check_zero("mid_hold");
        end
        release_reset();
        repeat (4) step(0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            bit v;
            int px, py;
            v  = ($urandom_range(0, 7) != 0);
            px = ($urandom_range(0, 15) == 0) ? 639 : int'($urandom_range(0, 700));
            py = ($urandom_range(0, 15) == 0) ? 479 : int'($urandom_range(0, 511));
            step(v, px, py);
        end
        repeat (4) step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
